// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request-port arbiter: FSM encoding and requester ids.
package l2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_L1I = 0;
  localparam int unsigned REQ_L1D = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first active request at or above ptr, with wrap.
module rr_picker
  import l2_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               grant_valid_c
);

  // Scan from farthest to nearest offset so the nearest active index wins.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = 32'(ptr) + (k - 1);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        grant_idx_c   = IDX_W'(idx);
        grant_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between NUM_REQ L1 requesters.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN (adds req_err port).
module l2_port_arbiter
  import l2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         l2_addr,
  output logic [DATA_WIDTH-1:0]         l2_wdata,
  input  logic [DATA_WIDTH-1:0]         l2_rdata,
  output logic                          l2_read,
  output logic                          l2_write,
  input  logic                          l2_ready
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          req_err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e              state, state_d;
  logic [IDX_W-1:0]        owner, owner_d, rr_ptr, rr_ptr_d, next_ptr;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_valid;
  logic [NUM_REQ-1:0]      req_act, owner_onehot, req_ready_d;
  logic [ADDR_WIDTH-1:0]   sel_addr, l2_addr_d;
  logic [DATA_WIDTH-1:0]   sel_wdata, l2_wdata_d, req_rdata_d;
  logic                    sel_write, l2_read_d, l2_write_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             req_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign req_act      = req_read | req_write;
  assign owner_onehot = NUM_REQ'(1) << owner;
  assign next_ptr     = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req           (req_act),
    .ptr           (rr_ptr),
    .grant_idx_c   (grant_idx),
    .grant_valid_c (grant_valid)
  );

  // Mux the granted requester's address, data and operation.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    l2_addr_d   = l2_addr;
    l2_wdata_d  = l2_wdata;
    l2_read_d   = l2_read;
    l2_write_d  = l2_write;
    req_ready_d = req_ready;
    req_rdata_d = req_rdata;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    req_err_d   = req_err;
`endif
    case (state)
      ST_IDLE: begin
        req_ready_d = '0;
        if (grant_valid) begin
          state_d    = ST_ISSUE;
          owner_d    = grant_idx;
          l2_addr_d  = sel_addr;
          l2_wdata_d = sel_wdata;
          l2_write_d = sel_write;
          l2_read_d  = ~sel_write;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (l2_ready) begin
          state_d     = ST_DONE;
          l2_read_d   = 1'b0;
          l2_write_d  = 1'b0;
          req_ready_d = owner_onehot;
          rr_ptr_d    = next_ptr;
          if (!l2_write) req_rdata_d = l2_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_DONE;
          l2_read_d   = 1'b0;
          l2_write_d  = 1'b0;
          req_ready_d = owner_onehot;
          rr_ptr_d    = next_ptr;
          req_rdata_d = '0;
          req_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = '0;
`ifdef ARB_TIMEOUT_EN
        req_err_d   = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= IDX_W'(REQ_L1I);
      rr_ptr    <= IDX_W'(REQ_L1I);
      l2_addr   <= '0;
      l2_wdata  <= '0;
      l2_read   <= 1'b0;
      l2_write  <= 1'b0;
      req_ready <= '0;
      req_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      req_err   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_ptr    <= rr_ptr_d;
      l2_addr   <= l2_addr_d;
      l2_wdata  <= l2_wdata_d;
      l2_read   <= l2_read_d;
      l2_write  <= l2_write_d;
      req_ready <= req_ready_d;
      req_rdata <= req_rdata_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_d;
      req_err   <= req_err_d;
`endif
    end
  end

endmodule
